// File: rtl/video_rx_timing.sv
// video_rx_timing: RGB888 receiver with sync edge detection, pixel coordinate
// recovery, h/v timing measurement and a frame-to-frame lock detector.
// Optional HS watchdog is built when VIDEO_RX_TIMEOUT_EN is defined.
module video_rx_timing #(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter logic [11:0] TIMEOUT_CYC = 12'd4095
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic        video_hs,
  input  logic        video_vs,
  input  logic        video_de,
  input  logic [23:0] video_rgb,
  output logic        pixel_valid,
  output logic [23:0] pixel_data,
  output logic [11:0] pixel_xpos,
  output logic [11:0] pixel_ypos,
  output logic        frame_start,
  output logic        line_end,
  output logic [11:0] h_total,
  output logic [11:0] h_active,
  output logic [11:0] v_total,
  output logic [11:0] v_active,
  output logic        locked,
  output logic        fmt_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FIRST   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  // Saturating 12-bit increment shared by all counters.
  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    sat_inc = (v == 12'hFFF) ? v : (v + 12'd1);
  endfunction

  // Stage 1 and its one-cycle history
  logic        s1_hs_q, s1_vs_q, s1_de_q;
  logic [23:0] s1_rgb_q;
  logic        hs_prev_q, vs_prev_q, de_prev_q;
  logic        hs_fall_s, vs_fall_s, de_fall_s;

  // Measurement counters
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] meas_htot_q, meas_htot_d;
  logic [11:0] de_cnt_q, de_cnt_d;
  logic [11:0] meas_hact_q, meas_hact_d;
  logic [11:0] line_cnt_q, line_cnt_d;
  logic [11:0] act_lines_q, act_lines_d;
  logic [11:0] act_lines_inc_s;
  logic [11:0] x_cnt_q, x_cnt_d;
  logic        fs_pend_q, fs_pend_d;

  // Frame tuple presented to the lock FSM at vs_fall
  logic [11:0] htot_new_s, hact_new_s, vtot_new_s, vact_new_s;
  logic        tuple_eq_s;
  logic [11:0] xpos_cur_s, ypos_cur_s;

  // Output stage
  logic        valid_q, fs_q, le_q;
  logic [23:0] data_q;
  logic [11:0] xpos_q, ypos_q;

  // Lock FSM
  state_e      state_q;
  logic [3:0]  match_q;
  logic [3:0]  match_inc_s;
  logic [11:0] ref_htot_q, ref_hact_q, ref_vtot_q, ref_vact_q;
  logic        locked_q, fmt_err_q;
  logic        timeout_s;

  // Register raw inputs and keep the previous stage-1 value for edge detection.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_hs_q   <= 1'b0;
      s1_vs_q   <= 1'b0;
      s1_de_q   <= 1'b0;
      s1_rgb_q  <= 24'd0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      de_prev_q <= 1'b0;
    end else begin
      s1_hs_q   <= video_hs;
      s1_vs_q   <= video_vs;
      s1_de_q   <= video_de;
      s1_rgb_q  <= video_rgb;
      hs_prev_q <= s1_hs_q;
      vs_prev_q <= s1_vs_q;
      de_prev_q <= s1_de_q;
    end
  end

  assign hs_fall_s = hs_prev_q & ~s1_hs_q;
  assign vs_fall_s = vs_prev_q & ~s1_vs_q;
  assign de_fall_s = de_prev_q & ~s1_de_q;

  // Next-state logic for all timing counters and the measured tuple.
  always_comb begin
    h_cnt_d     = h_cnt_q;
    meas_htot_d = meas_htot_q;
    de_cnt_d    = de_cnt_q;
    meas_hact_d = meas_hact_q;
    line_cnt_d  = line_cnt_q;
    act_lines_d = act_lines_q;
    x_cnt_d     = x_cnt_q;
    fs_pend_d   = fs_pend_q;

    // Line length: restart at 1 on hs_fall so the latched value is the period.
    if (hs_fall_s) begin
      h_cnt_d     = 12'd1;
      meas_htot_d = h_cnt_q;
    end else begin
      h_cnt_d = sat_inc(h_cnt_q);
    end

    // Active width: DE cycles latched at the trailing edge of DE.
    if (de_fall_s) begin
      meas_hact_d = de_cnt_q;
      de_cnt_d    = 12'd0;
    end else if (s1_de_q) begin
      de_cnt_d = sat_inc(de_cnt_q);
    end else begin
      de_cnt_d = de_cnt_q;
    end

    // Frame height: a coincident hs_fall is line 1 of the new frame.
    if (vs_fall_s) begin
      line_cnt_d = hs_fall_s ? 12'd1 : 12'd0;
    end else if (hs_fall_s) begin
      line_cnt_d = sat_inc(line_cnt_q);
    end else begin
      line_cnt_d = line_cnt_q;
    end

    // Active lines: a de_fall coincident with vs_fall still belongs to the old frame.
    if (vs_fall_s) begin
      act_lines_d = 12'd0;
    end else begin
      act_lines_d = act_lines_inc_s;
    end

    // Column counter restarts on every hs_fall, even mid-DE.
    if (hs_fall_s) begin
      x_cnt_d = s1_de_q ? 12'd1 : 12'd0;
    end else if (s1_de_q) begin
      x_cnt_d = sat_inc(x_cnt_q);
    end else begin
      x_cnt_d = x_cnt_q;
    end

    // Armed by vs_fall, consumed by the first valid pixel.
    if (s1_de_q) begin
      fs_pend_d = 1'b0;
    end else if (vs_fall_s) begin
      fs_pend_d = 1'b1;
    end else begin
      fs_pend_d = fs_pend_q;
    end
  end

  assign act_lines_inc_s = de_fall_s ? sat_inc(act_lines_q) : act_lines_q;
  assign htot_new_s      = hs_fall_s ? h_cnt_q : meas_htot_q;
  assign hact_new_s      = de_fall_s ? de_cnt_q : meas_hact_q;
  assign vtot_new_s      = line_cnt_q;
  assign vact_new_s      = act_lines_inc_s;
  assign tuple_eq_s      = (htot_new_s == ref_htot_q) && (hact_new_s == ref_hact_q) &&
                           (vtot_new_s == ref_vtot_q) && (vact_new_s == ref_vact_q);
  assign xpos_cur_s      = hs_fall_s ? 12'd0 : x_cnt_q;
  assign ypos_cur_s      = vs_fall_s ? 12'd0 : act_lines_q;
  assign match_inc_s     = match_q + 4'd1;

  // Timing counter state.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt_q     <= 12'd0;
      meas_htot_q <= 12'd0;
      de_cnt_q    <= 12'd0;
      meas_hact_q <= 12'd0;
      line_cnt_q  <= 12'd0;
      act_lines_q <= 12'd0;
      x_cnt_q     <= 12'd0;
      fs_pend_q   <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      meas_htot_q <= meas_htot_d;
      de_cnt_q    <= de_cnt_d;
      meas_hact_q <= meas_hact_d;
      line_cnt_q  <= line_cnt_d;
      act_lines_q <= act_lines_d;
      x_cnt_q     <= x_cnt_d;
      fs_pend_q   <= fs_pend_d;
    end
  end

  // Pixel output stage; line_end looks one sample ahead at the incoming DE.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 24'd0;
      xpos_q  <= 12'd0;
      ypos_q  <= 12'd0;
      fs_q    <= 1'b0;
      le_q    <= 1'b0;
    end else begin
      valid_q <= s1_de_q;
      data_q  <= s1_de_q ? s1_rgb_q : 24'd0;
      xpos_q  <= s1_de_q ? xpos_cur_s : 12'd0;
      ypos_q  <= s1_de_q ? ypos_cur_s : 12'd0;
      fs_q    <= s1_de_q & (fs_pend_q | vs_fall_s);
      le_q    <= s1_de_q & ~video_de;
    end
  end

`ifdef VIDEO_RX_TIMEOUT_EN
  logic [11:0] wd_q, wd_d;

  // Watchdog next state: cleared by hs_fall, holds once at the limit.
  always_comb begin
    if (hs_fall_s) begin
      wd_d = 12'd0;
    end else if (wd_q == TIMEOUT_CYC) begin
      wd_d = wd_q;
    end else begin
      wd_d = wd_q + 12'd1;
    end
  end

  assign timeout_s = ~hs_fall_s & (wd_q == (TIMEOUT_CYC - 12'd1));

  // Watchdog counter.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wd_q <= 12'd0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic [11:0] timeout_unused_s;
  assign timeout_unused_s = TIMEOUT_CYC;
  assign timeout_s        = 1'b0;
`endif

  // Lock FSM: compares each frame's tuple against the stored reference at vs_fall.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      match_q    <= 4'd0;
      ref_htot_q <= 12'd0;
      ref_hact_q <= 12'd0;
      ref_vtot_q <= 12'd0;
      ref_vact_q <= 12'd0;
      locked_q   <= 1'b0;
      fmt_err_q  <= 1'b0;
    end else begin
      fmt_err_q <= 1'b0;
      if (timeout_s) begin
        fmt_err_q  <= (state_q == ST_LOCKED);
        state_q    <= ST_IDLE;
        match_q    <= 4'd0;
        ref_htot_q <= 12'd0;
        ref_hact_q <= 12'd0;
        ref_vtot_q <= 12'd0;
        ref_vact_q <= 12'd0;
        locked_q   <= 1'b0;
      end else if (vs_fall_s) begin
        case (state_q)
          ST_IDLE: begin
            state_q  <= ST_FIRST;
            locked_q <= 1'b0;
          end
          ST_FIRST: begin
            ref_htot_q <= htot_new_s;
            ref_hact_q <= hact_new_s;
            ref_vtot_q <= vtot_new_s;
            ref_vact_q <= vact_new_s;
            match_q    <= 4'd0;
            state_q    <= ST_MEASURE;
            locked_q   <= 1'b0;
          end
          ST_MEASURE: begin
            if (tuple_eq_s) begin
              match_q <= match_inc_s;
              if (match_inc_s >= LOCK_N) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end else begin
                state_q  <= ST_MEASURE;
                locked_q <= 1'b0;
              end
            end else begin
              ref_htot_q <= htot_new_s;
              ref_hact_q <= hact_new_s;
              ref_vtot_q <= vtot_new_s;
              ref_vact_q <= vact_new_s;
              match_q    <= 4'd0;
              locked_q   <= 1'b0;
            end
          end
          ST_LOCKED: begin
            if (!tuple_eq_s) begin
              fmt_err_q  <= 1'b1;
              ref_htot_q <= htot_new_s;
              ref_hact_q <= hact_new_s;
              ref_vtot_q <= vtot_new_s;
              ref_vact_q <= vact_new_s;
              match_q    <= 4'd0;
              state_q    <= ST_MEASURE;
              locked_q   <= 1'b0;
            end else begin
              locked_q <= 1'b1;
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            match_q  <= 4'd0;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pixel_valid = valid_q;
  assign pixel_data  = data_q;
  assign pixel_xpos  = xpos_q;
  assign pixel_ypos  = ypos_q;
  assign frame_start = fs_q;
  assign line_end    = le_q;
  assign h_total     = ref_htot_q;
  assign h_active    = ref_hact_q;
  assign v_total     = ref_vtot_q;
  assign v_active    = ref_vact_q;
  assign locked      = locked_q;
  assign fmt_err     = fmt_err_q;

endmodule

// File: tb/tb_video_rx_timing.sv
// Scoreboard bench for video_rx_timing using a reduced raster so whole frames
// fit in a short run: 40x12 total, 24x6 active, HS 4 + HBP 6, VS 2 + VBP 3.
module tb_video_rx_timing;
  localparam int HT = 40, HA = 24, HSW = 4, HBP = 6;
  localparam int VT = 12, VA = 6, VSW = 2, VBP = 3;
  localparam int HDE0 = HSW + HBP;
  localparam int VDE0 = VSW + VBP;

  logic        pixel_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        video_hs = 1'b1, video_vs = 1'b1, video_de = 1'b0;
  logic [23:0] video_rgb = 24'hFFFFFF;
  logic        pixel_valid, frame_start, line_end, locked, fmt_err;
  logic [23:0] pixel_data;
  logic [11:0] pixel_xpos, pixel_ypos, h_total, h_active, v_total, v_active;

  video_rx_timing dut (
    .pixel_clk(pixel_clk), .sys_rst_n(sys_rst_n),
    .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de), .video_rgb(video_rgb),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .frame_start(frame_start), .line_end(line_end),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .locked(locked), .fmt_err(fmt_err)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    int          slot;
    logic [23:0] rgb;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
    logic        le;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   slot = 0, fmt_cnt = 0, fmt_slot = -1, last_hs_fall = 0;
  logic prev_vs_m = 1'b0, prev_hs_m = 1'b0, pend_m = 1'b0;

  function automatic logic in_act(input int l, input int h, input int ha);
    return (l >= VDE0) && (l < VDE0 + VA) && (h >= HDE0) && (h < HDE0 + ha);
  endfunction

  // One pixel slot: check what the DUT presents now, then drive the next sample.
  task automatic step(input logic hs, input logic vs, input logic de, input logic [23:0] rgb,
                      input int x, input int y, input logic le);
    exp_t e;
    logic vsf;
    @(negedge pixel_clk);
    if (fmt_err) begin
      fmt_cnt++;
      fmt_slot = slot;
    end
    if (pixel_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid: slot %0d pixel_valid=1 required 0", slot);
      end else begin
        e = sb.pop_front();
        checks++;
        if (e.slot + 2 !== slot) begin
          errors++;
          $display("FAIL latency: pixel from slot %0d seen at %0d required %0d", e.slot, slot, e.slot + 2);
        end
        checks++;
        if (pixel_data !== e.rgb) begin
          errors++;
          $display("FAIL pixel_data: slot %0d got %h required %h", slot, pixel_data, e.rgb);
        end
        checks++;
        if (pixel_xpos !== e.x || pixel_ypos !== e.y) begin
          errors++;
          $display("FAIL xy: slot %0d got (%0d,%0d) required (%0d,%0d)", slot, pixel_xpos, pixel_ypos, e.x, e.y);
        end
        checks++;
        if (frame_start !== e.fs || line_end !== e.le) begin
          errors++;
          $display("FAIL markers: slot %0d got fs=%b le=%b required fs=%b le=%b", slot, frame_start, line_end, e.fs, e.le);
        end
      end
    end else begin
      checks++;
      if (pixel_data !== 24'd0 || pixel_xpos !== 12'd0 || pixel_ypos !== 12'd0 ||
          frame_start !== 1'b0 || line_end !== 1'b0) begin
        errors++;
        $display("FAIL blank_zero: slot %0d got data=%h x=%0d y=%0d fs=%b le=%b required all 0",
                 slot, pixel_data, pixel_xpos, pixel_ypos, frame_start, line_end);
      end
      if (sb.size() > 0) begin
        checks++;
        if (sb[0].slot + 2 <= slot) begin
          errors++;
          $display("FAIL missing_pixel: slot %0d pixel_valid=0 required 1 for slot %0d", slot, sb[0].slot);
          void'(sb.pop_front());
        end
      end
    end
    video_hs  = hs;
    video_vs  = vs;
    video_de  = de;
    video_rgb = rgb;
    if (prev_hs_m && !hs) last_hs_fall = slot;
    vsf = prev_vs_m && !vs;
    if (de) begin
      e.slot = slot;
      e.rgb  = rgb;
      e.x    = 12'(x);
      e.y    = 12'(y);
      e.fs   = pend_m || vsf;
      e.le   = le;
      sb.push_back(e);
      pend_m = 1'b0;
    end else if (vsf) begin
      pend_m = 1'b1;
    end
    prev_vs_m = vs;
    prev_hs_m = hs;
    slot++;
  endtask

  task automatic drive_sample(input int l, input int h, input int ha);
    logic de;
    de = in_act(l, h, ha);
    step(h >= HSW, l >= VSW, de, de ? 24'($urandom) : 24'hFFFFFF,
         h - HDE0, l - VDE0, de & ~in_act(l, h + 1, ha));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 24'hFFFFFF, 0, 0, 1'b0);
  endtask

  // Full frame; lock status is checked just after this frame's opening vs_fall.
  task automatic drive_frame(input int ha, input logic exp_lock, input int exp_fmt);
    fmt_cnt = 0;
    for (int l = 0; l < VT; l++) begin
      for (int h = 0; h < HT; h++) begin
        drive_sample(l, h, ha);
        if (l == 0 && h == 3) begin
          checks++;
          if (locked !== exp_lock) begin
            errors++;
            $display("FAIL locked_at_vs: slot %0d got %b required %b", slot, locked, exp_lock);
          end
          checks++;
          if (fmt_cnt !== exp_fmt) begin
            errors++;
            $display("FAIL fmt_err_pulses: slot %0d got %0d required %0d", slot, fmt_cnt, exp_fmt);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge pixel_clk);
    checks++;
    if ({pixel_valid, pixel_data, pixel_xpos, pixel_ypos, frame_start, line_end,
         h_total, h_active, v_total, v_active, locked, fmt_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h locked=%b h_total=%0d required all 0",
               pixel_valid, pixel_data, locked, h_total);
    end
    sys_rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_lock_acquire();
    drive_frame(HA, 1'b0, 0);
    drive_frame(HA, 1'b0, 0);
    drive_frame(HA, 1'b0, 0);
    drive_frame(HA, 1'b1, 0);
    checks++;
    if (h_total !== 12'(HT) || h_active !== 12'(HA) || v_total !== 12'(VT) || v_active !== 12'(VA)) begin
      errors++;
      $display("FAIL tuple_lock: got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
               h_total, h_active, v_total, v_active, HT, HA, VT, VA);
    end
  endtask

  task automatic test_locked_pixels();
    drive_frame(HA, 1'b1, 0);
    drive_frame(HA, 1'b1, 0);
  endtask

  task automatic test_fmt_change();
    drive_frame(HA - 1, 1'b1, 0);
    drive_frame(HA, 1'b0, 1);
    checks++;
    if (h_active !== 12'(HA - 1)) begin
      errors++;
      $display("FAIL tuple_after_err: h_active got %0d required %0d", h_active, HA - 1);
    end
    drive_frame(HA, 1'b0, 0);
    drive_frame(HA, 1'b0, 0);
    drive_frame(HA, 1'b1, 0);
    checks++;
    if (h_active !== 12'(HA)) begin
      errors++;
      $display("FAIL tuple_relock: h_active got %0d required %0d", h_active, HA);
    end
  endtask

  task automatic test_reset_midline();
    for (int l = 0; l < 7; l++)
      for (int h = 0; h < HT; h++) drive_sample(l, h, HA);
    for (int h = 0; h < 20; h++) drive_sample(7, h, HA);
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({pixel_valid, pixel_data, pixel_xpos, pixel_ypos, frame_start, line_end,
         h_total, h_active, v_total, v_active, locked, fmt_err} !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%h x=%0d locked=%b h_total=%0d required all 0",
               pixel_valid, pixel_data, pixel_xpos, locked, h_total);
    end
    sb.delete();
    prev_vs_m = 1'b0;
    prev_hs_m = 1'b0;
    pend_m    = 1'b0;
    video_hs  = 1'b1;
    video_vs  = 1'b1;
    video_de  = 1'b0;
    video_rgb = 24'hFFFFFF;
    @(negedge pixel_clk);
    sys_rst_n = 1'b1;
    idle(5);
    drive_frame(HA, 1'b0, 0);
    drive_frame(HA, 1'b0, 0);
    drive_frame(HA, 1'b0, 0);
    drive_frame(HA, 1'b1, 0);
  endtask

  task automatic test_hs_stuck();
    fmt_cnt  = 0;
    fmt_slot = -1;
    idle(4300);
`ifdef VIDEO_RX_TIMEOUT_EN
    checks++;
    if (fmt_cnt !== 1) begin
      errors++;
      $display("FAIL timeout_pulse: got %0d pulses required 1", fmt_cnt);
    end
    checks++;
    if (fmt_slot - last_hs_fall < 4094 || fmt_slot - last_hs_fall > 4100) begin
      errors++;
      $display("FAIL timeout_delay: got %0d slots required about 4095", fmt_slot - last_hs_fall);
    end
    checks++;
    if (locked !== 1'b0 || {h_total, h_active, v_total, v_active} !== 48'd0) begin
      errors++;
      $display("FAIL timeout_state: locked=%b tuple=%0d/%0d/%0d/%0d required 0 and all 0",
               locked, h_total, h_active, v_total, v_active);
    end
`else
    checks++;
    if (locked !== 1'b1 || fmt_cnt !== 0) begin
      errors++;
      $display("FAIL hs_stuck_hold: locked=%b pulses=%0d required 1 and 0", locked, fmt_cnt);
    end
    checks++;
    if (h_total !== 12'(HT)) begin
      errors++;
      $display("FAIL hs_stuck_tuple: h_total got %0d required %0d", h_total, HT);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_locked_pixels();
    test_fmt_change();
    test_reset_midline();
    test_hs_stuck();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
